fv_instr_feeder: RTL and testbench
==================================

# fv_instr_feeder

Formal/verification instruction source that sits directly upstream of the cache subsystem's instruction-fetch response path. It is used when the IF stage is excluded (`FV_INCLUDE_IF_STAGE` undefined). It drives the `fv2if_ready`, `fv2if_instruction_valid` and `fv2if_instruction` nets consumed by the subsystem. Instruction words come from an unconstrained source (solver or testbench), are buffered in a small FIFO, and are returned to the frontend with icache-like request/kill/flush semantics.

## Interface

Parameters:
- FETCH_WIDTH, default ariane_pkg::FETCH_WIDTH (32): width of one fetch word.
- DEPTH, default 4: FIFO entries; power of two, ≥2.
- VLEN, default 64: width of the virtual address.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- src_valid_i  in  1  source offers a fetch word.
- src_data_i  in  FETCH_WIDTH  offered fetch word.
- src_ready_o  out  1  FIFO can accept; equals !full.
- req_i  in  1  frontend fetch request (icache_dreq_i.req).
- kill_s1_i  in  1  cancels the request in its acceptance cycle.
- kill_s2_i  in  1  cancels an outstanding request.
- vaddr_i  in  VLEN  request address, captured on acceptance.
- flush_i  in  1  icache flush; aborts the outstanding request.
- ready_o  out  1  drives fv2if_ready.
- valid_o  out  1  drives fv2if_instruction_valid.
- data_o  out  FETCH_WIDTH  drives fv2if_instruction; '0 when valid_o=0.
- vaddr_o  out  VLEN  captured address of the delivered word.
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation

- **FIFO.**
  - Circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Push when src_valid_i & src_ready_o. Pop when valid_o=1.
  - Simultaneous push and pop leaves count unchanged and the pointers each advance.
  - There is no bypass: a word pushed in cycle N is deliverable no earlier than cycle N+1.
- **FSM states: IDLE, RESP.**
  - IDLE:
    - ready_o=1.
    - req_i & !kill_s1_i & !flush_i moves to RESP and captures vaddr_i.
    - Otherwise remains in IDLE.
  - RESP, kill_s2_i | flush_i:
    - valid_o=0, no pop, ready_o=0.
    - Moves to IDLE.
  - RESP, count_o>0 (and no kill/flush):
    - valid_o=1, data_o=FIFO head, vaddr_o=captured vaddr, pop.
    - ready_o=1 (back-to-back acceptance).
    - req_i & !kill_s1_i stays in RESP and captures the new vaddr_i. Otherwise moves to IDLE.
  - RESP, count_o==0 (and no kill/flush):
    - Stall: valid_o=0, ready_o=0, remain in RESP.
- flush_i never clears FIFO contents. Buffered words remain valid across flushes.
- kill_s1_i and kill_s2_i both high in the RESP delivery cycle: kill_s2_i wins (no delivery), and the new request is not accepted.
- A req_i outside a cycle with ready_o=1 is ignored.

## Timing

- Reset values:
  - state=IDLE, count_o=0, pointers=0, vaddr reg=0.
  - ready_o=1, valid_o=0, data_o=0, vaddr_o=0, src_ready_o=1.
- Latency:
  - Request accepted in cycle N, FIFO non-empty → valid_o in cycle N+1.
  - If the FIFO is empty, valid_o arrives in the cycle after the first push.
- valid_o, ready_o and data_o are combinational from state, count, kill_s2_i and flush_i.
- There is no combinational path from req_i to valid_o.
- src_ready_o depends only on registered count. When full, a push is refused even in a pop cycle.
- Reset asserted mid-request:
  - The in-flight request and all FIFO contents are discarded asynchronously.
  - Outputs take their reset values immediately.
- Throughput: one word per cycle with continuous req_i and a non-empty FIFO.

## Test plan

- **Reset/idle:** hold rst_ni=0 then release with no stimulus → ready_o=1, valid_o=0, data_o=0, count_o=0, src_ready_o=1.
- **Single fetch:**
  - Push 0x00000013 in cycle 0.
  - Assert req_i with vaddr 0x80000000 in cycle 1.
  - Cycle 2: valid_o=1, data_o=0x00000013, vaddr_o=0x80000000. Then count_o=0.
- **Stall on empty:**
  - Assert req_i with an empty FIFO.
  - valid_o=0 and ready_o=0 for 3 cycles.
  - Push 0xDEADBEEF in cycle 3 → valid_o=1 with 0xDEADBEEF in cycle 4.
- **Kills and flush:**
  - req_i with kill_s1_i → stays IDLE.
  - Accepted request, then kill_s2_i → no delivery, count_o unchanged.
  - Same with flush_i → FIFO contents retained.
- **Full and wrap:**
  - Push 4 words A–D → src_ready_o=0 and a 5th push is refused.
  - Stream 4 back-to-back requests → A,B,C,D in order, one per cycle.
  - Refill with E–H across the pointer wrap → delivered in order.
- **Async reset mid-operation:** with count_o=3 and a request outstanding, pulse rst_ni low between clock edges → count_o=0, valid_o=0 immediately, and the next request stalls.

Source files
------------

// File: rtl/fv_instr_feeder.sv
// fv_instr_feeder: buffered instruction source standing in for the IF stage.
// Words from an unconstrained source are replayed with icache-like semantics.
module fv_instr_feeder #(
  parameter int unsigned FETCH_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned VLEN        = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         src_valid_i,
  input  logic [FETCH_WIDTH-1:0]       src_data_i,
  output logic                         src_ready_o,
  input  logic                         req_i,
  input  logic                         kill_s1_i,
  input  logic                         kill_s2_i,
  input  logic [VLEN-1:0]              vaddr_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [FETCH_WIDTH-1:0]       data_o,
  output logic [VLEN-1:0]              vaddr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  state_e                 state_q;
  logic [FETCH_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]          rd_ptr_q;
  logic [PW-1:0]          wr_ptr_q;
  logic [CW-1:0]          count_q;
  logic [VLEN-1:0]        vaddr_q;

  logic full;
  logic empty;
  logic abort;
  logic push;
  logic pop;
  logic accept;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign abort = kill_s2_i | flush_i;

  // Refusal on full holds even when a pop happens the same cycle.
  assign src_ready_o = !full;
  assign push        = src_valid_i & !full;

  assign valid_o = (state_q == RESP) & !abort & !empty;
  assign ready_o = (state_q == IDLE) | valid_o;
  assign pop     = valid_o;
  assign accept  = ready_o & req_i & !kill_s1_i & !flush_i;

  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign vaddr_o = vaddr_q;
  assign count_o = count_q;

  // Storage array: contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= src_data_i;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Request FSM and captured fetch address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      vaddr_q <= '0;
    end else begin
      if (accept) vaddr_q <= vaddr_i;
      unique case (state_q)
        IDLE: begin
          if (accept) state_q <= RESP;
        end
        RESP: begin
          if (abort)       state_q <= IDLE;
          else if (!empty) state_q <= accept ? RESP : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fv_instr_feeder.sv
// tb_fv_instr_feeder: directed plus randomized checks of fv_instr_feeder
// against a queue-based reference model.
module tb_fv_instr_feeder;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = '0;
  logic        src_ready_o;
  logic        req = 1'b0;
  logic        kill_s1 = 1'b0;
  logic        kill_s2 = 1'b0;
  logic [63:0] vaddr = '0;
  logic        flush = 1'b0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic [63:0] vaddr_o;
  logic [2:0]  count_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mq [$];
  bit          pend = 1'b0;
  logic [63:0] pva  = '0;

  always #5 clk = ~clk;

  fv_instr_feeder #(
    .FETCH_WIDTH(32),
    .DEPTH(4),
    .VLEN(64)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .src_valid_i(src_valid),
    .src_data_i (src_data),
    .src_ready_o(src_ready_o),
    .req_i      (req),
    .kill_s1_i  (kill_s1),
    .kill_s2_i  (kill_s2),
    .vaddr_i    (vaddr),
    .flush_i    (flush),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .vaddr_o    (vaddr_o),
    .count_o    (count_o)
  );

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // A word is delivered when a request is pending, not aborted,
  // and the buffer holds something.
  function automatic bit m_deliver();
    return pend && !(kill_s2 || flush) && (mq.size() > 0);
  endfunction

  function automatic bit m_ready();
    return !pend || m_deliver();
  endfunction

  // Reference model update.
  initial begin
    bit dl, rdy, psh, acc, ab;
    forever begin
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) begin
        mq.delete();
        pend = 1'b0;
        pva  = '0;
      end else begin
        dl  = m_deliver();
        rdy = m_ready();
        ab  = kill_s2 || flush;
        psh = src_valid && (mq.size() < 4);
        acc = rdy && req && !kill_s1 && !flush;
        if (dl) void'(mq.pop_front());
        if (psh) mq.push_back(src_data);
        if (acc) begin
          pend = 1'b1;
          pva  = vaddr;
        end else if (pend && (dl || ab)) begin
          pend = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_ni) begin
      chk("count", 64'(count_o), 64'(mq.size()));
      chk("src_ready", 64'(src_ready_o), 64'(mq.size() < 4));
      chk("ready", 64'(ready_o), 64'(m_ready()));
      chk("valid", 64'(valid_o), 64'(m_deliver()));
      chk("data", 64'(data_o), m_deliver() ? 64'(mq[0]) : 64'd0);
      if (m_deliver()) chk("vaddr", vaddr_o, pva);
    end
  end

  task automatic half();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] wa [4];
  logic [31:0] we [4];

  initial begin
    wa[0] = 32'hAAAA0001; wa[1] = 32'hBBBB0002;
    wa[2] = 32'hCCCC0003; wa[3] = 32'hDDDD0004;
    we[0] = 32'hEEEE0005; we[1] = 32'hFFFF0006;
    we[2] = 32'h99990007; we[3] = 32'h88880008;

    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    half();
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_src_ready", 64'(src_ready_o), 64'd1);
    chk("rst_vaddr", vaddr_o, 64'd0);
    nxt();

    // single fetch
    src_valid = 1'b1; src_data = 32'h00000013;
    half(); nxt();
    src_valid = 1'b0; req = 1'b1; vaddr = 64'h80000000;
    half(); nxt();
    req = 1'b0;
    half();
    chk("sf_valid", 64'(valid_o), 64'd1);
    chk("sf_data", 64'(data_o), 64'h13);
    chk("sf_vaddr", vaddr_o, 64'h80000000);
    nxt();
    half();
    chk("sf_count", 64'(count_o), 64'd0);
    nxt();

    // stall on empty
    req = 1'b1; vaddr = 64'h80000004;
    half(); nxt();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        src_valid = 1'b1; src_data = 32'hDEADBEEF;
      end
      half();
      chk("st_valid", 64'(valid_o), 64'd0);
      chk("st_ready", 64'(ready_o), 64'd0);
      nxt();
    end
    src_valid = 1'b0;
    half();
    chk("st_dvalid", 64'(valid_o), 64'd1);
    chk("st_data", 64'(data_o), 64'hDEADBEEF);
    chk("st_vaddr", vaddr_o, 64'h80000004);
    nxt();

    // kill_s1 keeps idle
    req = 1'b1; kill_s1 = 1'b1;
    half(); nxt();
    req = 1'b0; kill_s1 = 1'b0;
    half();
    chk("k1_ready", 64'(ready_o), 64'd1);
    nxt();

    // kill_s2 aborts, keeps contents
    src_valid = 1'b1; src_data = 32'h11112222;
    half(); nxt();
    src_valid = 1'b0; req = 1'b1; vaddr = 64'h10;
    half(); nxt();
    req = 1'b0; kill_s2 = 1'b1;
    half();
    chk("k2_valid", 64'(valid_o), 64'd0);
    chk("k2_count", 64'(count_o), 64'd1);
    nxt();
    kill_s2 = 1'b0;
    half();
    chk("k2_idle", 64'(ready_o), 64'd1);
    nxt();

    // flush aborts, keeps contents
    req = 1'b1;
    half(); nxt();
    req = 1'b0; flush = 1'b1;
    half();
    chk("fl_valid", 64'(valid_o), 64'd0);
    nxt();
    flush = 1'b0;
    half();
    chk("fl_count", 64'(count_o), 64'd1);
    nxt();
    req = 1'b1; vaddr = 64'h20;
    half(); nxt();
    req = 1'b0;
    half();
    chk("fl_data", 64'(data_o), 64'h11112222);
    chk("fl_vaddr", vaddr_o, 64'h20);
    nxt();

    // fill to full, then stream twice across the wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        src_valid = 1'b1;
        src_data  = (r == 0) ? wa[i] : we[i];
        half(); nxt();
      end
      src_data = 32'h55555555;
      half();
      chk("full_count", 64'(count_o), 64'd4);
      chk("full_src_ready", 64'(src_ready_o), 64'd0);
      nxt();
      src_valid = 1'b0;
      half();
      chk("full_refused", 64'(count_o), 64'd4);
      nxt();
      req = 1'b1; vaddr = 64'h100;
      half(); nxt();
      for (int i = 0; i < 4; i++) begin
        req   = (i < 3);
        vaddr = 64'h100 + 64'(4 * (i + 1));
        half();
        chk("strm_valid", 64'(valid_o), 64'd1);
        chk("strm_data", 64'(data_o), 64'((r == 0) ? wa[i] : we[i]));
        chk("strm_vaddr", vaddr_o, 64'h100 + 64'(4 * i));
        nxt();
      end
      req = 1'b0;
      half();
      chk("strm_empty", 64'(count_o), 64'd0);
      nxt();
    end

    // async reset with request outstanding
    for (int i = 0; i < 3; i++) begin
      src_valid = 1'b1; src_data = 32'h30 + 32'(i);
      half(); nxt();
    end
    src_valid = 1'b0; req = 1'b1; vaddr = 64'h40;
    half(); nxt();
    req = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("ar_count", 64'(count_o), 64'd0);
    chk("ar_valid", 64'(valid_o), 64'd0);
    chk("ar_ready", 64'(ready_o), 64'd1);
    chk("ar_data", 64'(data_o), 64'd0);
    #1 rst_ni = 1'b1;
    half(); nxt();
    req = 1'b1; vaddr = 64'h44;
    half(); nxt();
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      half();
      chk("ar_stall_valid", 64'(valid_o), 64'd0);
      chk("ar_stall_ready", 64'(ready_o), 64'd0);
      nxt();
    end
    src_valid = 1'b1; src_data = 32'h77;
    half(); nxt();
    src_valid = 1'b0;
    half();
    chk("ar_data_after", 64'(data_o), 64'h77);
    nxt();

    // randomized traffic
    repeat (3000) begin
      src_valid = ($urandom_range(0, 1) == 1);
      src_data  = $urandom;
      req       = ($urandom_range(0, 9) < 6);
      kill_s1   = ($urandom_range(0, 9) == 0);
      kill_s2   = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      vaddr     = {$urandom, $urandom};
      half(); nxt();
    end
    src_valid = 1'b0; req = 1'b0;
    kill_s1 = 1'b0; kill_s2 = 1'b0; flush = 1'b0;
    repeat (4) begin
      half(); nxt();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
